// File: rtl/router_register_gen.sv
// Router register block: header latching, output byte steering with a hold
// register for FIFO-full stalls, running packet check (XOR parity or
// truncated sum), payload length counting, and registered error flags.
module router_register_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2,
   parameter int NUM_CHAN   = 3,
   parameter int CHECK_MODE = 0
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             pkt_valid,
   input  logic [DATA_WIDTH-1:0]            data_in,
   input  logic                             fifo_full,
   input  logic                             detect_add,
   input  logic                             lfd_state,
   input  logic                             ld_state,
   input  logic                             laf_state,
   input  logic                             full_state,
   input  logic                             rst_int_reg,
   output logic [DATA_WIDTH-1:0]            dout,
   output logic                             err,
   output logic                             len_err,
   output logic                             parity_done,
   output logic                             low_packet_valid,
   output logic [DATA_WIDTH-ADDR_WIDTH-1:0] payload_count
);

   localparam int LEN_WIDTH = DATA_WIDTH - ADDR_WIDTH;
   localparam logic [LEN_WIDTH-1:0]  CNT_MAX    = '1;
   localparam logic [ADDR_WIDTH:0]   NUM_CHAN_L = (ADDR_WIDTH+1)'(NUM_CHAN);

   // State registers and their next-state values
   logic [DATA_WIDTH-1:0] dout_q,     dout_d;
   logic [DATA_WIDTH-1:0] header_q,   header_d;
   logic [DATA_WIDTH-1:0] hold_q,     hold_d;
   logic [DATA_WIDTH-1:0] check_q,    check_d;
   logic [DATA_WIDTH-1:0] pkt_chk_q,  pkt_chk_d;
   logic [LEN_WIDTH-1:0]  count_q,    count_d;
   logic                  err_q,      err_d;
   logic                  len_err_q,  len_err_d;
   logic                  pdone_q,    pdone_d;
   logic                  pdone_dly_q, pdone_dly_d;
   logic                  lpv_q,      lpv_d;

   // Decoded conditions
   logic addr_ok;
   logic data_upd;
   logic capture;
   logic pdone_rise;

   // Check accumulation step: XOR parity or modulo-2^DATA_WIDTH sum
   function automatic logic [DATA_WIDTH-1:0] check_step(
      input logic [DATA_WIDTH-1:0] acc,
      input logic [DATA_WIDTH-1:0] b
   );
      if (CHECK_MODE == 1) begin
         return acc + b;
      end else begin
         return acc ^ b;
      end
   endfunction

   // Condition decode shared by the next-state logic
   always_comb begin
      addr_ok    = ({1'b0, data_in[ADDR_WIDTH-1:0]} < NUM_CHAN_L);
      data_upd   = ld_state & pkt_valid & ~full_state;
      capture    = (ld_state & ~fifo_full & ~pkt_valid) |
                   (laf_state & lpv_q & ~pdone_q);
      pdone_rise = pdone_q & ~pdone_dly_q;
   end

   // Header latch, output byte steering and stall hold byte
   always_comb begin
      header_d = header_q;
      dout_d   = dout_q;
      hold_d   = hold_q;

      if (detect_add && pkt_valid && addr_ok) begin
         header_d = data_in;
      end

      if (lfd_state) begin
         dout_d = header_q;
      end else if (ld_state && !fifo_full) begin
         dout_d = data_in;
      end else if (laf_state) begin
         dout_d = hold_q;
      end

      if (ld_state && fifo_full) begin
         hold_d = data_in;
      end
   end

   // Per-packet check, length and error tracking; detect_add restarts a packet
   always_comb begin
      check_d     = check_q;
      count_d     = count_q;
      pkt_chk_d   = pkt_chk_q;
      pdone_d     = pdone_q;
      err_d       = err_q;
      len_err_d   = len_err_q;
      pdone_dly_d = pdone_q;

      if (detect_add) begin
         check_d   = '0;
         count_d   = '0;
         pdone_d   = 1'b0;
         err_d     = 1'b0;
         len_err_d = 1'b0;
      end else begin
         if (lfd_state) begin
            check_d = check_step(check_q, header_q);
         end else if (data_upd) begin
            check_d = check_step(check_q, data_in);
         end

         if (data_upd && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
         end

         if (capture) begin
            pkt_chk_d = data_in;
            pdone_d   = 1'b1;
         end

         // Evaluated one cycle after the check byte lands, so both the
         // running check and the captured byte are settled registers.
         if (pdone_rise) begin
            err_d     = (check_q != pkt_chk_q);
            len_err_d = (count_q != header_q[DATA_WIDTH-1:ADDR_WIDTH]);
         end
      end
   end

   // Low packet valid flag: set on a pkt_valid drop in LOAD_DATA, set wins
   always_comb begin
      lpv_d = lpv_q;
      if (ld_state && !pkt_valid) begin
         lpv_d = 1'b1;
      end else if (rst_int_reg) begin
         lpv_d = 1'b0;
      end
   end

   // State update with synchronous reset overriding everything
   always_ff @(posedge clock) begin
      if (reset) begin
         dout_q      <= '0;
         header_q    <= '0;
         hold_q      <= '0;
         check_q     <= '0;
         pkt_chk_q   <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
         len_err_q   <= 1'b0;
         pdone_q     <= 1'b0;
         pdone_dly_q <= 1'b0;
         lpv_q       <= 1'b0;
      end else begin
         dout_q      <= dout_d;
         header_q    <= header_d;
         hold_q      <= hold_d;
         check_q     <= check_d;
         pkt_chk_q   <= pkt_chk_d;
         count_q     <= count_d;
         err_q       <= err_d;
         len_err_q   <= len_err_d;
         pdone_q     <= pdone_d;
         pdone_dly_q <= pdone_dly_d;
         lpv_q       <= lpv_d;
      end
   end

   assign dout             = dout_q;
   assign err              = err_q;
   assign len_err          = len_err_q;
   assign parity_done      = pdone_q;
   assign low_packet_valid = lpv_q;
   assign payload_count    = count_q;

endmodule

// File: tb/tb_router_register_gen.sv
// Directed bench for router_register_gen: a dout scoreboard fed by a small
// reference model every cycle, plus directed flag checks at packet points.
module tb_router_register_gen;

   logic       clock;
   logic       rst, pv, ff, da, lfd, ld, laf, fs, ri;
   logic [7:0] din;

   logic [7:0] d0_dout, d1_dout;
   logic       d0_err, d0_len, d0_pd, d0_lpv;
   logic       d1_err, d1_len, d1_pd, d1_lpv;
   logic [5:0] d0_cnt, d1_cnt;

   int unsigned total;
   int unsigned passed;

   logic [7:0] exp_q[$];
   logic [7:0] m_hdr, m_hold, m_dout;

   router_register_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_CHAN(3), .CHECK_MODE(0)) dut0 (
      .clock(clock), .reset(rst), .pkt_valid(pv), .data_in(din), .fifo_full(ff),
      .detect_add(da), .lfd_state(lfd), .ld_state(ld), .laf_state(laf),
      .full_state(fs), .rst_int_reg(ri), .dout(d0_dout), .err(d0_err),
      .len_err(d0_len), .parity_done(d0_pd), .low_packet_valid(d0_lpv),
      .payload_count(d0_cnt)
   );

   router_register_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_CHAN(3), .CHECK_MODE(1)) dut1 (
      .clock(clock), .reset(rst), .pkt_valid(pv), .data_in(din), .fifo_full(ff),
      .detect_add(da), .lfd_state(lfd), .ld_state(ld), .laf_state(laf),
      .full_state(fs), .rst_int_reg(ri), .dout(d1_dout), .err(d1_err),
      .len_err(d1_len), .parity_done(d1_pd), .low_packet_valid(d1_lpv),
      .payload_count(d1_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      rst = 0; pv = 0; ff = 0; da = 0; lfd = 0; ld = 0; laf = 0; fs = 0; ri = 0; din = 8'h00;
   endtask

   // One clock: model pushes the expected dout, DUT result popped after the edge
   task automatic tick();
      logic [7:0] e;
      if (rst) begin
         m_hdr = 8'h00; m_hold = 8'h00; m_dout = 8'h00;
      end else begin
         if (lfd) m_dout = m_hdr;
         else if (ld && !ff) m_dout = din;
         else if (laf) m_dout = m_hold;
         if (ld && ff) m_hold = din;
         if (da && pv && (din[1:0] < 2'd3)) m_hdr = din;
      end
      exp_q.push_back(m_dout);
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("dout", 32'(d0_dout), 32'(e));
      end
      clr();
   endtask

   task automatic do_hdr(input logic [7:0] b);
      clr(); da = 1; pv = 1; din = b; tick();
   endtask
   task automatic do_lfd();
      clr(); lfd = 1; pv = 1; din = 8'hA5; tick();
   endtask
   task automatic do_ld(input logic [7:0] b);
      clr(); ld = 1; pv = 1; din = b; tick();
   endtask
   task automatic do_chk(input logic [7:0] b, input logic clr_int);
      clr(); ld = 1; pv = 0; din = b; ri = clr_int; tick();
   endtask
   task automatic do_idle(input logic clr_int);
      clr(); ri = clr_int; tick();
   endtask
   task automatic pkt_a(input logic [7:0] cb);
      do_hdr(8'h0E); do_lfd(); do_ld(8'h11); do_ld(8'h22); do_ld(8'h33); do_chk(cb, 1'b0);
   endtask

   initial begin
      total = 0; passed = 0;
      m_hdr = 8'h00; m_hold = 8'h00; m_dout = 8'h00;
      clr();

      // Reset state
      rst = 1; tick(); rst = 1; tick();
      chk("rst_err", 32'(d0_err), 0);
      chk("rst_len", 32'(d0_len), 0);
      chk("rst_pd", 32'(d0_pd), 0);
      chk("rst_lpv", 32'(d0_lpv), 0);
      chk("rst_cnt", 32'(d0_cnt), 0);

      // Good packet, parity mode
      pkt_a(8'h0E);
      chk("a_pd", 32'(d0_pd), 1);
      chk("a_cnt", 32'(d0_cnt), 3);
      chk("a_lpv", 32'(d0_lpv), 1);
      do_idle(1'b0);
      chk("a_err", 32'(d0_err), 0);
      chk("a_len", 32'(d0_len), 0);
      chk("a_sum_err", 32'(d1_err), 1);
      do_idle(1'b1);
      chk("a_lpv_clr", 32'(d0_lpv), 0);

      // Bad check byte; set of low_packet_valid wins over rst_int_reg
      do_hdr(8'h0E); do_lfd(); do_ld(8'h11); do_ld(8'h22); do_ld(8'h33);
      do_chk(8'h0F, 1'b1);
      chk("b_lpv_setwins", 32'(d0_lpv), 1);
      do_idle(1'b0);
      chk("b_err", 32'(d0_err), 1);
      chk("b_len", 32'(d0_len), 0);
      do_idle(1'b0); do_idle(1'b0); do_idle(1'b1);
      chk("b_err_hold", 32'(d0_err), 1);
      chk("b_pd_hold", 32'(d0_pd), 1);

      // Four payload bytes against a length of three
      do_hdr(8'h0E);
      chk("c_err_clr", 32'(d0_err), 0);
      chk("c_pd_clr", 32'(d0_pd), 0);
      chk("c_cnt_clr", 32'(d0_cnt), 0);
      do_lfd(); do_ld(8'h01); do_ld(8'h02); do_ld(8'h03); do_ld(8'h04);
      do_chk(8'h00, 1'b0);
      do_idle(1'b1);
      chk("c_len", 32'(d0_len), 1);
      chk("c_cnt", 32'(d0_cnt), 4);

      // FIFO full stall: dout holds, LOAD_AFTER_FULL releases the hold byte
      do_hdr(8'h0E); do_lfd(); do_ld(8'h11);
      clr(); ld = 1; pv = 1; ff = 1; din = 8'h5A; tick();
      chk("f_stall", 32'(d0_dout), 32'h11);
      clr(); laf = 1; pv = 1; din = 8'h00; tick();
      chk("f_laf", 32'(d0_dout), 32'h5A);
      chk("f_pd_none", 32'(d0_pd), 0);
      // Check byte arrives while full, captured in LOAD_AFTER_FULL
      clr(); ld = 1; pv = 0; ff = 1; din = 8'h45; tick();
      chk("f_pd_wait", 32'(d0_pd), 0);
      clr(); laf = 1; din = 8'h45; tick();
      chk("f_laf_pd", 32'(d0_pd), 1);
      do_idle(1'b1);
      chk("f_err", 32'(d0_err), 0);
      chk("f_len", 32'(d0_len), 1);

      // Invalid address leaves header unchanged
      do_hdr(8'h0F); do_lfd();
      chk("inv_hdr", 32'(d0_dout), 32'h0E);
      do_idle(1'b0);

      // Sum mode packet
      pkt_a(8'h74);
      do_idle(1'b1);
      chk("s_sum_err", 32'(d1_err), 0);
      chk("s_par_err", 32'(d0_err), 1);

      // Abort by reset mid-packet, then a clean packet
      do_hdr(8'h0E); do_lfd(); do_ld(8'h11); do_ld(8'h22);
      rst = 1; tick();
      chk("r_dout", 32'(d0_dout), 0);
      chk("r_cnt", 32'(d0_cnt), 0);
      chk("r_pd", 32'(d0_pd), 0);
      chk("r_err", 32'(d0_err), 0);
      chk("r_lpv", 32'(d0_lpv), 0);
      pkt_a(8'h0E);
      do_idle(1'b1);
      chk("r2_err", 32'(d0_err), 0);
      chk("r2_len", 32'(d0_len), 0);
      chk("r2_cnt", 32'(d0_cnt), 3);

      // Payload counter saturates
      do_hdr(8'h0E); do_lfd();
      for (int i = 0; i < 70; i++) do_ld(8'(i));
      chk("sat_cnt", 32'(d0_cnt), 63);
      do_idle(1'b0);

      chk("sb_empty", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
